// File: rtl/inst_queue_if.sv
// Fetch-to-decode bundle type and the queue's handshake interface.
// The package sits here so the struct and the interface travel together.
package inst_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
    } pipe_in_t;

endpackage

interface inst_queue_if #(
    parameter int DEPTH = 8
);
    import inst_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    pipe_in_t      pipe_in;
    logic          enable;
    logic          out_valid;
    logic          out_ready;
    pipe_in_t      pipe_out;
    logic [CW-1:0] count;

    modport master (
        output in_valid,
        output pipe_in,
        output out_ready,
        input  enable,
        input  out_valid,
        input  pipe_out,
        input  count
    );

    modport slave (
        input  in_valid,
        input  pipe_in,
        input  out_ready,
        output enable,
        output out_valid,
        output pipe_out,
        output count
    );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction buffer between fetch and decode/issue.
// Stalls fetch when full; a commit flush discards every entry.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    inst_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pipe_in_t      mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic          clear;

    assign clear         = reset | flush;
    assign bus.enable    = (cnt != CW'(DEPTH));
    assign bus.out_valid = (cnt != '0);
    assign bus.pipe_out  = mem[rd_ptr];
    assign bus.count     = cnt;

    assign push = bus.in_valid & bus.enable & ~clear;
    assign pop  = bus.out_valid & bus.out_ready & ~clear;

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.pipe_in;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: expected bundles are queued at push
// time and a negedge monitor compares them as decode consumes them.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic mon_on = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int       m_count = 0;
    pipe_in_t sb [$];

    inst_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [66:0] act,
                       input logic [66:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    function automatic pipe_in_t mk(input logic [31:0] pc,
                                    input logic p,
                                    input logic b,
                                    input logic j);
        pipe_in_t t;
        t.pc          = pc;
        t.instruction = pc ^ 32'hA5A5_0013;
        t.prediction  = p;
        t.branch      = b;
        t.jump        = j;
        return t;
    endfunction

    // Reference occupancy and expected-output queue.
    always @(posedge clk) begin
        logic mp;
        logic mq;
        mp = bus.in_valid && (m_count != DEPTH)
             && !flush && !reset;
        mq = (m_count != 0) && bus.out_ready
             && !flush && !reset;
        if (reset || flush) begin
            m_count <= 0;
            sb.delete();
        end else begin
            if (mq)
                void'(sb.pop_front());
            if (mp)
                sb.push_back(bus.pipe_in);
            m_count <= m_count + int'(mp) - int'(mq);
        end
    end

    // Monitor: status every cycle, data whenever decode takes a bundle.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("count", 67'(bus.count), 67'(m_count));
            chk("enable", 67'(bus.enable),
                67'(m_count != DEPTH));
            chk("out_valid", 67'(bus.out_valid),
                67'(m_count != 0));
            if (bus.out_valid && bus.out_ready
                && !flush && !reset) begin
                if (sb.size() == 0)
                    chk("sb_empty", 67'(bus.pipe_out), 67'(0));
                else
                    chk("pipe_out", bus.pipe_out, sb[0]);
            end
        end
    end

    task automatic drive(input logic iv,
                         input pipe_in_t p,
                         input logic ordy,
                         input logic fl,
                         input logic rs);
        bus.in_valid  = iv;
        bus.pipe_in   = p;
        bus.out_ready = ordy;
        flush         = fl;
        reset         = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, mk(32'hDEAD_0000, 1'b0, 1'b0, 1'b0),
              ordy, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.pipe_in   = '0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        mon_on = 1'b1;
        chk("rst_count", 67'(bus.count), 67'(0));
        chk("rst_enable", 67'(bus.enable), 67'(1));
        chk("rst_valid", 67'(bus.out_valid), 67'(0));

        // Single push then pop.
        drive(1'b1, mk(32'h100, 1'b0, 1'b0, 1'b0),
              1'b0, 1'b0, 1'b0);
        chk("single_valid", 67'(bus.out_valid), 67'(1));
        chk("single_pc", 67'(bus.pipe_out.pc), 67'(32'h100));
        chk("single_count", 67'(bus.count), 67'(1));
        idle(1'b1);
        chk("single_pop_count", 67'(bus.count), 67'(0));
        chk("single_pop_valid", 67'(bus.out_valid), 67'(0));

        // Fill to full, then a rejected push.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, mk(32'(i * 4), 1'b0, 1'b0, 1'(i)),
                  1'b0, 1'b0, 1'b0);
        chk("full_enable", 67'(bus.enable), 67'(0));
        chk("full_count", 67'(bus.count), 67'(8));
        drive(1'b1, mk(32'h20, 1'b0, 1'b0, 1'b0),
              1'b0, 1'b0, 1'b0);
        chk("full_reject", 67'(bus.count), 67'(8));

        // Push and pop together while full: only the pop happens.
        drive(1'b1, mk(32'h24, 1'b0, 1'b0, 1'b0),
              1'b1, 1'b0, 1'b0);
        chk("fullpp_count", 67'(bus.count), 67'(7));
        chk("fullpp_enable", 67'(bus.enable), 67'(1));
        chk("fullpp_head", 67'(bus.pipe_out.pc), 67'(32'h4));
        for (int i = 0; i < 7; i++)
            idle(1'b1);
        chk("drain_count", 67'(bus.count), 67'(0));

        // Back-to-back stream across two pointer wraps.
        for (int i = 0; i < 20; i++) begin
            if (i == 5)
                drive(1'b1, mk(32'h200 + 32'(i * 4),
                      1'b1, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
            else
                drive(1'b1, mk(32'h200 + 32'(i * 4),
                      1'(i), 1'(i >> 1), 1'(i >> 2)),
                      1'b1, 1'b0, 1'b0);
            chk("stream_count", 67'(bus.count), 67'(1));
            if (i == 5)
                chk("branch_bundle", bus.pipe_out,
                    mk(32'h214, 1'b1, 1'b1, 1'b0));
        end
        idle(1'b1);
        chk("stream_end", 67'(bus.count), 67'(0));

        // Flush with five entries and a push/pop pending.
        for (int i = 0; i < 5; i++)
            drive(1'b1, mk(32'h300 + 32'(i * 4),
                  1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("preflush_count", 67'(bus.count), 67'(5));
        drive(1'b1, mk(32'h3F0, 1'b0, 1'b0, 1'b0),
              1'b1, 1'b1, 1'b0);
        chk("flush_count", 67'(bus.count), 67'(0));
        chk("flush_valid", 67'(bus.out_valid), 67'(0));
        chk("flush_enable", 67'(bus.enable), 67'(1));
        drive(1'b1, mk(32'h400, 1'b0, 1'b0, 1'b1),
              1'b0, 1'b0, 1'b0);
        chk("postflush_valid", 67'(bus.out_valid), 67'(1));
        chk("postflush_pc", 67'(bus.pipe_out.pc), 67'(32'h400));
        idle(1'b1);

        // Reset and flush together with three entries.
        for (int i = 0; i < 3; i++)
            drive(1'b1, mk(32'h500 + 32'(i * 4),
                  1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("prereset_count", 67'(bus.count), 67'(3));
        drive(1'b1, mk(32'h5F0, 1'b0, 1'b0, 1'b0),
              1'b1, 1'b1, 1'b1);
        chk("rstfl_count", 67'(bus.count), 67'(0));
        chk("rstfl_valid", 67'(bus.out_valid), 67'(0));
        chk("rstfl_enable", 67'(bus.enable), 67'(1));
        drive(1'b1, mk(32'h600, 1'b1, 1'b0, 1'b1),
              1'b0, 1'b0, 1'b0);
        chk("postrst_pc", 67'(bus.pipe_out.pc), 67'(32'h600));
        idle(1'b1);
        chk("final_count", 67'(bus.count), 67'(0));
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Circular instruction buffer between the fetch stage and decode/issue. Accepts one `pipe_in_t` bundle (pc, instruction, prediction, branch, jump) per cycle from fetch and presents the oldest entry to decode under a valid/ready handshake. Drives the fetch `enable` (stall) signal when full. Discards all contents on a mispredict flush from commit.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..64.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  mispredict/redirect from commit; discard all entries.
- `in_valid`  in  1  fetch bundle on `pipe_in` is valid this cycle.
- `pipe_in`  in  pipe_in_t (67)  fetch bundle: pc[31:0], instruction[31:0], prediction, branch, jump.
- `enable`  out  1  to fetch; 1 when the queue can accept a push this cycle (not full).
- `out_valid`  out  1  `pipe_out` holds the oldest entry.
- `out_ready`  in  1  decode accepts `pipe_out` this cycle.
- `pipe_out`  out  pipe_in_t (67)  oldest entry, unmodified copy of the pushed bundle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH x pipe_in_t array, read pointer `rd_ptr`, write pointer `wr_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter `count`.
- push = `in_valid & enable & ~flush`; writes `pipe_in` at `wr_ptr`, `wr_ptr` increments.
- pop = `out_valid & out_ready & ~flush`; `rd_ptr` increments.
- `count` next = count + push − pop; push and pop in the same cycle leave `count` unchanged.
- `enable` = (count != DEPTH). Combinational from registered `count` only; never depends on `out_ready`. When full, a simultaneous pop does not permit a push that cycle.
- `out_valid` = (count != 0); `pipe_out` = array[rd_ptr], combinational read of registered state.
- Empty: no bypass; a bundle pushed into an empty queue is visible at `pipe_out` the following cycle.
- Flush: `rd_ptr`, `wr_ptr`, `count` reset to 0 at the next edge. Flush overrides push and pop in the same cycle; the bundle on `pipe_in` that cycle is dropped and nothing is dequeued. Array contents need not be cleared.
- Entries are never reordered or modified; `prediction`, `branch`, and `jump` pass through bit-exact.
- Pointer wrap: after `wr_ptr` = DEPTH−1, the next push writes entry 0. The same wrap rule applies to `rd_ptr`.

## Timing
- Reset (synchronous, active-high): pointers and `count` set to 0 → `out_valid`=0, `enable`=1, `count`=0 from the first edge with `reset` high until the first push after it deasserts. `pipe_out` is don't-care while `out_valid`=0.
- Reset asserted mid-operation behaves exactly like flush, and also takes priority over flush.
- Push-to-output latency: 1 cycle. A push at edge N gives `out_valid`=1 after edge N when the queue was empty.
- Sustained throughput: 1 push and 1 pop per cycle when 0 < count < DEPTH.
- `enable` deasserts in the cycle after the push that makes count = DEPTH. It reasserts in the cycle after the first pop from full.
- Fetch is responsible for holding its PC while `enable`=0. Any `in_valid` while `enable`=0 is ignored.
- Flush latency: 1 cycle. After a flush edge, `out_valid`=0 and `enable`=1. A push in the cycle immediately following the flush is accepted.

## Test plan
- Reset then single push, pc=0x100, instr=0x00000013 → `out_valid`=0 in the push cycle; next cycle `out_valid`=1, `pipe_out.pc`=0x100, `count`=1. After pop with `out_ready`=1 → `count`=0, `out_valid`=0.
- Fill with DEPTH=8: push pcs 0x0..0x1C with `out_ready`=0 → after 8th push `enable`=0, `count`=8. A 9th push of pc=0x20 is ignored. Pop 8 → pcs come out 0x0..0x1C in order.
- Full with simultaneous push+pop: count=8, `in_valid`=1, `out_ready`=1 → pop occurs, push rejected, `count`=7, `enable`=1 next cycle.
- Steady stream across wrap: 20 back-to-back pushes with `out_ready`=1 → `count` holds at 1 after the first cycle. Outputs are in order with no loss through two pointer wraps. Branch bundle (prediction=1, branch=1, jump=0) is preserved bit-exact.
- Flush with `count`=5 plus simultaneous `in_valid`/`out_ready` → next cycle `count`=0, `out_valid`=0, `enable`=1. The flushing-cycle bundle is not enqueued. A push one cycle later appears at `pipe_out` the cycle after.
- Reset asserted with `count`=3 and flush=1 in the same cycle → `count`=0, `out_valid`=0, `enable`=1. Behaviour is identical to a plain reset.
